// File: rtl/counter_monitor.sv
// counter_monitor: watches an up/down count against a threshold, raising a
// registered alarm after two consecutive over-threshold samples and dropping it
// only once the count falls to a hysteresis level below the threshold. Also
// tracks a sticky alarm flag, the peak value seen and a saturating entry count.
module counter_monitor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HYST  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value_in,
    input  logic [WIDTH-1:0] thresh_in,
    input  logic             clear_in,
    output logic             alarm_out,
    output logic             sticky_out,
    output logic [WIDTH-1:0] peak_out,
    output logic [15:0]      events_out
);

    typedef enum logic [1:0] {
        StNormal,
        StPending,
        StAlarm
    } state_e;

    localparam logic [WIDTH-1:0] HystW = WIDTH'(HYST);

    state_e           state_q, state_d;
    logic             alarm_q, alarm_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] peak_q, peak_d;
    logic [15:0]      events_q, events_d;

    logic             over;
    logic             under;
    logic             entry;
    logic [WIDTH-1:0] clear_level;

    // Threshold comparisons; clear level floors at zero for small thresholds.
    always_comb begin
        over        = value_in > thresh_in;
        clear_level = (thresh_in >= HystW) ? (thresh_in - HystW) : '0;
        under       = value_in <= clear_level;
    end

    // Next-state logic for the alarm FSM.
    always_comb begin
        state_d = state_q;
        entry   = 1'b0;
        unique case (state_q)
            StNormal: begin
                if (over) state_d = StPending;
            end
            StPending: begin
                if (over) begin
                    state_d = StAlarm;
                    entry   = 1'b1;
                end else begin
                    state_d = StNormal;
                end
            end
            StAlarm: begin
                if (under) state_d = StNormal;
            end
            default: state_d = StNormal;
        endcase
        alarm_d = (state_d == StAlarm);
    end

    // Status next-state: an alarm entry in the same cycle as clear_in wins.
    always_comb begin
        sticky_d = sticky_q;
        peak_d   = peak_q;
        events_d = events_q;

        if (entry) begin
            sticky_d = 1'b1;
        end else if (clear_in) begin
            sticky_d = 1'b0;
        end

        if (clear_in) begin
            peak_d = value_in;
        end else if (value_in > peak_q) begin
            peak_d = value_in;
        end

        if (clear_in) begin
            events_d = entry ? 16'd1 : 16'd0;
        end else if (entry && (events_q != 16'hFFFF)) begin
            events_d = events_q + 16'd1;
        end
    end

    // State and status registers; rst overrides clear_in and every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StNormal;
            alarm_q  <= 1'b0;
            sticky_q <= 1'b0;
            peak_q   <= '0;
            events_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            alarm_q  <= alarm_d;
            sticky_q <= sticky_d;
            peak_q   <= peak_d;
            events_q <= events_d;
        end
    end

    assign alarm_out  = alarm_q;
    assign sticky_out = sticky_q;
    assign peak_out   = peak_q;
    assign events_out = events_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench for counter_monitor (WIDTH=8, HYST=4): directed scenarios
// followed by randomized traffic, checked against a streak-counting model.
module tb_counter_monitor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] value_in;
    logic [W-1:0] thresh_in;
    logic         clear_in;
    logic         alarm_out;
    logic         sticky_out;
    logic [W-1:0] peak_out;
    logic [15:0]  events_out;

    counter_monitor #(
        .WIDTH(W),
        .HYST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value_in  (value_in),
        .thresh_in (thresh_in),
        .clear_in  (clear_in),
        .alarm_out (alarm_out),
        .sticky_out(sticky_out),
        .peak_out  (peak_out),
        .events_out(events_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit alarm;
        bit sticky;
        int peak;
        int events;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model state
    bit m_alarm  = 0;
    int m_streak = 0;
    bit m_sticky = 0;
    int m_peak   = 0;
    int m_events = 0;

    task automatic model_step(input int v, input int t, input bit c, input bit r);
        int  cl;
        bit  entry;
        exp_t e;
        entry = 0;
        if (r) begin
            m_alarm = 0; m_streak = 0; m_sticky = 0; m_peak = 0; m_events = 0;
        end else begin
            cl = (t >= 4) ? t - 4 : 0;
            if (m_alarm) begin
                if (v <= cl) m_alarm = 0;
            end else if (v > t) begin
                m_streak++;
                if (m_streak == 2) begin
                    m_alarm  = 1;
                    m_streak = 0;
                    entry    = 1;
                end
            end else begin
                m_streak = 0;
            end
            m_peak = c ? v : ((v > m_peak) ? v : m_peak);
            if (entry) m_sticky = 1;
            else if (c) m_sticky = 0;
            if (c) m_events = entry ? 1 : 0;
            else if (entry) m_events = (m_events < 65535) ? m_events + 1 : 65535;
        end
        e.alarm = m_alarm; e.sticky = m_sticky; e.peak = m_peak;
        e.events = m_events; e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs at the negedge and record the expected result.
    task automatic step(input int v, input int t, input bit c, input bit r);
        value_in  = W'(v);
        thresh_in = W'(t);
        clear_in  = c;
        rst       = r;
        model_step(v, t, c, r);
        cyc++;
        @(negedge clk);
    endtask

    // Monitor: compare DUT outputs just after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests += 4;
                if (alarm_out !== e.alarm) begin
                    fails++;
                    $display("FAIL alarm cyc %0d: got %0b expected %0b", e.cyc, alarm_out, e.alarm);
                end
                if (sticky_out !== e.sticky) begin
                    fails++;
                    $display("FAIL sticky cyc %0d: got %0b expected %0b", e.cyc, sticky_out,
                             e.sticky);
                end
                if (peak_out !== W'(e.peak)) begin
                    fails++;
                    $display("FAIL peak cyc %0d: got %0d expected %0d", e.cyc, peak_out, e.peak);
                end
                if (events_out !== 16'(e.events)) begin
                    fails++;
                    $display("FAIL events cyc %0d: got %0d expected %0d", e.cyc, events_out,
                             e.events);
                end
            end
        end
    end

    initial begin
        int v, t, r, d;
        value_in = '0; thresh_in = 8'd100; clear_in = 0; rst = 1;
        @(negedge clk);

        // Reset state
        step(0, 100, 0, 1);
        step(0, 100, 0, 1);

        // Entry: two consecutive overs raise the alarm
        step(101, 100, 0, 0);
        step(101, 100, 0, 0);
        step(101, 100, 0, 0);
        // Hysteresis: 97 holds, 96 clears
        step(97, 100, 0, 0);
        step(98, 100, 0, 0);
        step(96, 100, 0, 0);
        step(50, 100, 0, 0);
        // Interrupted streak: no alarm
        step(101, 100, 0, 0);
        step(99, 100, 0, 0);
        step(101, 100, 0, 0);
        step(0, 100, 0, 0);

        // Low threshold: clear level is 0
        step(3, 2, 0, 0);
        step(3, 2, 0, 0);
        step(1, 2, 0, 0);
        step(2, 2, 0, 0);
        step(0, 2, 0, 0);
        step(0, 2, 0, 0);

        // Clear coincident with alarm entry
        step(150, 100, 0, 0);
        step(150, 100, 1, 0);
        step(120, 100, 0, 0);
        step(0, 100, 1, 0);
        step(0, 100, 0, 0);

        // Reset mid-alarm, value held at 150 afterwards
        step(150, 100, 0, 0);
        step(150, 100, 0, 0);
        step(150, 100, 0, 0);
        step(150, 100, 0, 1);
        step(150, 100, 0, 0);
        step(150, 100, 0, 0);
        step(150, 100, 0, 0);
        step(0, 100, 0, 0);
        step(0, 100, 0, 0);

        // Saturation: preload the entry count one below the limit
        force dut.events_q = 16'hFFFE;
        m_events = 65534;
        step(0, 100, 0, 0);
        release dut.events_q;
        step(101, 100, 0, 0);
        step(101, 100, 0, 0);
        step(0, 100, 0, 0);
        step(101, 100, 0, 0);
        step(101, 100, 0, 0);
        step(0, 100, 0, 0);
        step(0, 100, 1, 0);

        // Randomized traffic around a wandering threshold
        t = 100;
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 4) t = $urandom_range(0, 255);
            d = $urandom_range(0, 13);
            v = t + d - 8;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            step(v, t, (r >= 4 && r < 10), (r == 199));
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
